ads_spi_master: RTL and testbench
=================================

ADS_SPI_MASTER -- requirements
Module: ads_spi_master

Interface
REQ-001 Parameter: DIV_DEFAULT, 24, reset value of the DCLK half-period divider register.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  2  Avalon-MM slave register select.
REQ-005 chipselect  input  1  Avalon-MM slave select.
REQ-006 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 writedata  input  32  Avalon-MM write data.
REQ-008 readdata  output  32  Avalon-MM read data; combinational mux, zero-extended.
REQ-009 ads_ncs  output  1  touch-controller chip select, active-low.
REQ-010 ads_dclk  output  1  serial clock to the controller; idles low.
REQ-011 ads_din  output  1  serial command data to the controller.
REQ-012 ads_dout  input  1  serial conversion data from the controller.
REQ-013 ads_penirq  input  1  pen-down interrupt from the controller, active-low, asynchronous.
REQ-014 irq  output  1  level interrupt, high while done=1 and ie=1.

Function
REQ-015 Register map: 0 CMD (W, bits[7:0]); 1 STATUS (R: bit0 busy, bit1 done, bit2 pen_down, bit3 ie; W: bit1=1 clears done, bit3 writes ie); 2 RESULT (R, bits[11:0]); 3 DIV (R/W, bits[7:0]).
REQ-016 Write occurs when chipselect=1 and write_n=0; reads have no side effects.
REQ-017 CMD write while busy=0 latches the byte, sets busy, clears done, and starts a frame in the next cycle; a CMD write while busy=1 is ignored.
REQ-018 FSM states: IDLE, SETUP, SHIFT, HOLD; IDLE->SETUP on an accepted CMD write; SETUP->SHIFT after one half-period; SHIFT->HOLD after the 24th DCLK falling edge; HOLD->IDLE after one half-period.
REQ-019 ads_ncs is low in SETUP, SHIFT and HOLD, and high in IDLE.
REQ-020 Half-period equals DIV+1 clk cycles; DIV is sampled at frame start and must not change timing mid-frame.
REQ-021 A frame is exactly 24 DCLK periods, each low half then high half.
REQ-022 ads_din carries CMD bit 7-k during DCLK period k (k=0..7), MSB first, stable across the rising edge; it is 0 for periods 8..23 and in IDLE.
REQ-023 ads_dout is sampled on the DCLK rising edges of periods 9..20 into RESULT[11:0], MSB first; all other periods are ignored.
REQ-024 RESULT updates only at frame completion (HOLD->IDLE); it holds the old value during a frame.
REQ-025 On HOLD->IDLE: busy=0, done=1.
REQ-026 If a STATUS done-clear and frame completion coincide, done=1 wins.
REQ-027 ads_penirq is synchronised through two flops; pen_down = inverted synchronised value.
REQ-028 DIV=0 is legal and gives DCLK = clk/2.

Reset
REQ-029 reset_n low, asynchronous: FSM=IDLE, ads_ncs=1, ads_dclk=0, ads_din=0, busy=0, done=0, ie=0, irq=0, RESULT=0, CMD=0, DIV=DIV_DEFAULT, sync flops=1.
REQ-030 Reset mid-frame aborts immediately with all outputs at their reset values; no partial RESULT is retained.

Structure
REQ-031 Register addresses, STATUS bit positions, FSM state encoding and the frame constants (24, 9, 20) reside in a shared package ads_pkg.
REQ-032 One sub-module, ads_clk_div, generates the half-period tick from DIV; everything else is in ads_spi_master.

Verification
REQ-033 Reset check: reset -> readdata at addr 3 = 24, addr 1 = 0, ads_ncs=1, ads_dclk=0.
REQ-034 Frame check: DIV=1, CMD=0x93, controller model returns 0xA5C -> ads_din shows 1,0,0,1,0,0,1,1; 24 DCLK pulses of period 4 clk; RESULT=0xA5C; STATUS=0x2.
REQ-035 Busy rejection: CMD=0xD3 written mid-frame of 0x93 -> frame unchanged; a subsequent frame sends 0x93's successor only when written after done.
REQ-036 Interrupt: ie=1, frame completes -> irq=1; write STATUS bit1=1 -> irq=0 the next cycle.
REQ-037 Mid-frame reset: reset_n pulsed at DCLK period 12 -> ads_ncs=1 immediately; RESULT=0; next CMD produces a correct full frame.
REQ-038 Pen and coincidence: ads_penirq=0 -> STATUS bit2=1 within 2 clk; done-clear written in the completion cycle -> done=1.

Source files
------------

// File: rtl/ads_pkg.sv
// Shared constants for the touch-controller SPI master: register map, STATUS bits, FSM encoding, frame shape.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ads_pkg;

    // Avalon-MM register addresses
    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_RESULT = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    // STATUS bit positions
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_PEN  = 2;
    localparam int ST_IE   = 3;

    // Frame shape: 24 DCLK periods, command in periods 0..7, result sampled in periods 9..20
    localparam int FRAME_PERIODS = 24;
    localparam int CMD_PERIODS   = 8;
    localparam int SAMPLE_FIRST  = 9;
    localparam int SAMPLE_LAST   = 20;

    // Index of the final half-period inside SHIFT (high half of the last period)
    localparam logic [5:0] LAST_HALF = 6'(2 * FRAME_PERIODS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // True for the DCLK periods whose rising edge captures a result bit
    function automatic logic in_sample_window(input logic [4:0] period);
        return (period >= 5'(SAMPLE_FIRST)) && (period <= 5'(SAMPLE_LAST));
    endfunction

endpackage

// File: rtl/ads_clk_div.sv
// Half-period tick generator: pulses tick once every div+1 cycles while enabled.
// Latency: first tick div+1 cycles after en rises; counter restarts at zero whenever en is low.
// Backpressure: none; free-running while en is high.
module ads_clk_div (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == div);

    // Count clk cycles within the current half-period; wrap on tick, park at zero when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ads_spi_master.sv
// Avalon-MM controlled SPI master for an ADS784x-style touch controller: one 24-DCLK frame per CMD write.
// Latency: frame starts the cycle after an accepted CMD write; done rises (DIV+1)*50 cycles later.
// Backpressure: CMD writes while busy are dropped; software polls busy/done or uses irq.
module ads_spi_master
    import ads_pkg::*;
#(
    parameter int DIV_DEFAULT = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ads_ncs,
    output logic        ads_dclk,
    output logic        ads_din,
    input  logic        ads_dout,
    input  logic        ads_penirq,
    output logic        irq
);

    localparam logic [7:0] DIV_RST = 8'(DIV_DEFAULT);

    state_t      state;
    logic [5:0]  half_cnt;
    logic [7:0]  cmd_byte;
    logic [7:0]  div_reg;
    logic [7:0]  div_frame;
    logic [11:0] shreg;
    logic [11:0] result;
    logic        done;
    logic        ie;
    logic        pen_s1;
    logic        pen_s2;
    logic        tick;

    logic        wr_en;
    logic        busy;
    logic        cmd_accept;
    logic        frame_end;
    logic [5:0]  next_half;
    logic [4:0]  next_period;
    logic        next_din;
    logic        unused_wdata;

    assign wr_en       = chipselect && !write_n;
    assign busy        = (state != S_IDLE);
    assign cmd_accept  = wr_en && (address == ADDR_CMD) && !busy;
    assign frame_end   = (state == S_HOLD) && tick;
    assign next_half   = half_cnt + 6'd1;
    assign next_period = next_half[5:1];
    assign next_din    = (next_period < 5'(CMD_PERIODS)) ? cmd_byte[3'd7 - next_period[2:0]] : 1'b0;
    assign irq         = done && ie;
    assign unused_wdata = ^writedata[31:8];

    ads_clk_div u_clk_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (busy),
        .div     (div_frame),
        .tick    (tick)
    );

    // Frame sequencer: drives ncs/dclk/din as registers and shifts in the conversion result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ads_ncs   <= 1'b1;
            ads_dclk  <= 1'b0;
            ads_din   <= 1'b0;
            half_cnt  <= '0;
            cmd_byte  <= '0;
            div_frame <= DIV_RST;
            shreg     <= '0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_accept) begin
                        state     <= S_SETUP;
                        ads_ncs   <= 1'b0;
                        ads_dclk  <= 1'b0;
                        ads_din   <= writedata[7];
                        cmd_byte  <= writedata[7:0];
                        div_frame <= div_reg;
                        half_cnt  <= '0;
                        shreg     <= '0;
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        if (half_cnt == LAST_HALF) begin
                            state    <= S_HOLD;
                            ads_dclk <= 1'b0;
                            ads_din  <= 1'b0;
                        end else begin
                            half_cnt <= next_half;
                            ads_dclk <= next_half[0];
                            if (!next_half[0]) begin
                                ads_din <= next_din;
                            end else if (in_sample_window(half_cnt[5:1])) begin
                                shreg <= {shreg[10:0], ads_dout};
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        state   <= S_IDLE;
                        ads_ncs <= 1'b1;
                        result  <= shreg;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Software-visible control: done flag (completion beats a same-cycle clear), interrupt enable, divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done    <= 1'b0;
            ie      <= 1'b0;
            div_reg <= DIV_RST;
        end else begin
            if (frame_end) begin
                done <= 1'b1;
            end else if (cmd_accept) begin
                done <= 1'b0;
            end else if (wr_en && (address == ADDR_STATUS) && writedata[ST_DONE]) begin
                done <= 1'b0;
            end
            if (wr_en && (address == ADDR_STATUS)) begin
                ie <= writedata[ST_IE];
            end
            if (wr_en && (address == ADDR_DIV)) begin
                div_reg <= writedata[7:0];
            end
        end
    end

    // Two-flop synchroniser for the asynchronous pen-down line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pen_s1 <= 1'b1;
            pen_s2 <= 1'b1;
        end else begin
            pen_s1 <= ads_penirq;
            pen_s2 <= pen_s1;
        end
    end

    // Read mux, zero-extended; reads never change state
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: begin
                readdata[ST_BUSY] = busy;
                readdata[ST_DONE] = done;
                readdata[ST_PEN]  = !pen_s2;
                readdata[ST_IE]   = ie;
            end
            ADDR_RESULT: readdata[11:0] = result;
            ADDR_DIV:    readdata[7:0]  = div_reg;
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ads_spi_master.sv
// Directed bench for ads_spi_master with a behavioural touch-controller model on the serial pins.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ads_spi_master;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ads_ncs;
    logic        ads_dclk;
    logic        ads_din;
    logic        ads_dout;
    logic        ads_penirq;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Controller model state
    logic [11:0] mdl_val = 12'h000;
    int          rise_cnt = 0;
    int          last_frame_rises = 0;
    int          cyc = 0;
    int          last_rise = 0;
    int          per_min = 0;
    int          per_max = 0;
    logic [23:0] din_log = '0;
    logic [31:0] rv;

    ads_spi_master #(.DIV_DEFAULT(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .ads_ncs    (ads_ncs),
        .ads_dclk   (ads_dclk),
        .ads_din    (ads_din),
        .ads_dout   (ads_dout),
        .ads_penirq (ads_penirq),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Count DCLK rising edges per frame, log din at each rise, and measure the DCLK period
    always @(posedge ads_dclk or posedge ads_ncs) begin
        if (ads_ncs) begin
            last_frame_rises = rise_cnt;
            rise_cnt = 0;
        end else begin
            if (rise_cnt == 0) begin
                per_min = 1000000;
                per_max = 0;
            end else begin
                if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            last_rise = cyc;
            din_log = {din_log[22:0], ads_din};
            rise_cnt = rise_cnt + 1;
        end
    end

    // Controller drives the result MSB first, changing dout on the falling edge before periods 9..20
    always @(negedge ads_dclk) begin
        if (rise_cnt >= 9 && rise_cnt <= 20) ads_dout = mdl_val[20 - rise_cnt];
        else ads_dout = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_rise(input int n, input logic need_low);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (rise_cnt == n && (!need_low || !ads_dclk)) ok = 1'b1;
        end
        chk("wait_rise_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_frame();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (ads_ncs) ok = 1'b1;
        end
        chk("wait_frame_reached", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        ads_penirq = 1'b1;
        ads_dout   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        rd(2'd3, rv); chk("reset_div", rv, 32'd24);
        rd(2'd1, rv); chk("reset_status", rv, 32'h0);
        rd(2'd2, rv); chk("reset_result", rv, 32'h0);
        chk("reset_ncs", {31'd0, ads_ncs}, 32'd1);
        chk("reset_dclk", {31'd0, ads_dclk}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // Frame with DIV=1, CMD=0x93, controller returns 0xA5C; a CMD write mid-frame is dropped
        wr(2'd3, 32'd1);
        rd(2'd3, rv); chk("div_readback", rv, 32'd1);
        mdl_val = 12'hA5C;
        wr(2'd0, 32'h93);
        rd(2'd1, rv); chk("busy_after_cmd", rv, 32'h1);
        chk("ncs_low_in_frame", {31'd0, ads_ncs}, 32'd0);
        wait_rise(4, 1'b0);
        wr(2'd0, 32'hD3);
        rd(2'd2, rv); chk("result_held_mid_frame", rv, 32'h0);
        wait_frame();
        chk("f1_rises", last_frame_rises, 32'd24);
        chk("f1_period_min", per_min, 32'd4);
        chk("f1_period_max", per_max, 32'd4);
        chk("f1_din", {8'd0, din_log}, 32'h930000);
        rd(2'd2, rv); chk("f1_result", rv, 32'hA5C);
        rd(2'd1, rv); chk("f1_status", rv, 32'h2);

        // Next command after done goes out; CMD accept clears done
        mdl_val = 12'h123;
        wr(2'd0, 32'h94);
        rd(2'd1, rv); chk("f2_status_busy", rv, 32'h1);
        wait_frame();
        chk("f2_din", {8'd0, din_log}, 32'h940000);
        rd(2'd2, rv); chk("f2_result", rv, 32'h123);

        // Interrupt: enable, run a frame, then clear done
        wr(2'd1, 32'hA);
        rd(2'd1, rv); chk("ie_set_done_clr", rv, 32'h8);
        chk("irq_low_before", {31'd0, irq}, 32'd0);
        mdl_val = 12'hFFF;
        wr(2'd0, 32'h11);
        wait_frame();
        chk("irq_high_on_done", {31'd0, irq}, 32'd1);
        rd(2'd2, rv); chk("f3_result", rv, 32'hFFF);
        wr(2'd1, 32'hA);
        chk("irq_low_after_clear", {31'd0, irq}, 32'd0);
        rd(2'd1, rv); chk("status_after_clear", rv, 32'h8);

        // Done-clear written in the exact completion cycle: done stays set
        mdl_val = 12'h801;
        wr(2'd0, 32'h22);
        wait_rise(24, 1'b1);
        wr(2'd1, 32'h2);
        rd(2'd1, rv); chk("coincide_done_wins", rv, 32'h2);
        rd(2'd2, rv); chk("f4_result", rv, 32'h801);
        chk("f4_din", {8'd0, din_log}, 32'h220000);

        // Pen-down through the two-flop synchroniser
        @(negedge clk);
        ads_penirq = 1'b0;
        address    = 2'd1;
        @(posedge clk); #1;
        chk("pen_after_1clk", {31'd0, readdata[2]}, 32'd0);
        @(posedge clk); #1;
        chk("pen_after_2clk", {31'd0, readdata[2]}, 32'd1);
        @(negedge clk);
        ads_penirq = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during DCLK period 12 aborts the frame immediately
        mdl_val = 12'h5A5;
        wr(2'd0, 32'h77);
        wait_rise(12, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_ncs", {31'd0, ads_ncs}, 32'd1);
        chk("midrst_dclk", {31'd0, ads_dclk}, 32'd0);
        chk("midrst_din", {31'd0, ads_din}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, rv); chk("midrst_result", rv, 32'h0);
        rd(2'd1, rv); chk("midrst_status", rv, 32'h0);
        rd(2'd3, rv); chk("midrst_div", rv, 32'd24);

        // Full frame at the fastest divider (DIV=0, DCLK = clk/2)
        wr(2'd3, 32'd0);
        mdl_val = 12'h3C7;
        wr(2'd0, 32'h5A);
        wait_frame();
        chk("f5_rises", last_frame_rises, 32'd24);
        chk("f5_period_min", per_min, 32'd2);
        chk("f5_period_max", per_max, 32'd2);
        chk("f5_din", {8'd0, din_log}, 32'h5A0000);
        rd(2'd2, rv); chk("f5_result", rv, 32'h3C7);
        rd(2'd1, rv); chk("f5_status", rv, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
